// File: rtl/led_matrix_scan.sv
// led_matrix_scan: scans two 16x16 frames (red/green) onto one-hot row and column pins with a blank gap at every row change.
// Latency: frame_start is high 1 cycle after enable is sampled; row 0 drives after 1+BLANK_CYCLES cycles; each row lasts ROW_HOLD cycles.
// Backpressure: none. enable low stops the scan on the next edge. Macro LED_SCAN_DOUBLE_BUFFER_EN selects shadow frames, otherwise the columns read the live inputs.
module led_matrix_scan #(
  parameter int ROW_HOLD     = 1024,
  parameter int BLANK_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [15:0][15:0]  red_array,
  input  logic [15:0][15:0]  green_array,
  output logic [15:0]        row_out,
  output logic [15:0]        red_col,
  output logic [15:0]        green_col,
  output logic [3:0]         row_idx,
  output logic               frame_start
);

  // Dwell counter width. It must reach ROW_HOLD-1.
  localparam int CW = $clog2(ROW_HOLD);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(ROW_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t        r_ps;
  logic [3:0]    r_row;
  logic [CW-1:0] r_cnt;

  state_t        w_ns;
  logic [3:0]    w_row_nxt;
  logic [CW-1:0] w_cnt_nxt;

  // Present state, row and dwell counter. Reset and enable-low both return to a clean IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ps  <= S_IDLE;
      r_row <= 4'd0;
      r_cnt <= '0;
    end else begin
      r_ps  <= w_ns;
      r_row <= w_row_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Next-state logic. enable low takes priority over dwell and row advance.
  always_comb begin
    w_ns      = r_ps;
    w_row_nxt = r_row;
    w_cnt_nxt = r_cnt;
    unique case (r_ps)
      S_IDLE: begin
        if (enable) begin
          w_ns      = S_BLANK;
          w_row_nxt = 4'd0;
          w_cnt_nxt = '0;
        end
      end
      S_BLANK: begin
        if (!enable) begin
          w_ns      = S_IDLE;
          w_row_nxt = 4'd0;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == BLANK_LAST) begin
            w_ns = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (!enable) begin
          w_ns      = S_IDLE;
          w_row_nxt = 4'd0;
          w_cnt_nxt = '0;
        end else if (r_cnt == HOLD_LAST) begin
          // The row wraps 15 -> 0 naturally through the 4-bit add.
          w_ns      = S_BLANK;
          w_cnt_nxt = '0;
          w_row_nxt = r_row + 4'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_ns      = S_IDLE;
        w_row_nxt = 4'd0;
        w_cnt_nxt = '0;
      end
    endcase
  end

  logic [15:0] w_red_row;
  logic [15:0] w_green_row;

`ifdef LED_SCAN_DOUBLE_BUFFER_EN
  logic [15:0][15:0] r_red_shadow;
  logic [15:0][15:0] r_green_shadow;
  logic              w_latch;

  // The shadows load when scanning starts and again on the edge where row 15 wraps to row 0.
  // The input value present on that edge is the one captured.
  assign w_latch = enable &&
                   ((r_ps == S_IDLE) ||
                    ((r_ps == S_DRIVE) && (r_cnt == HOLD_LAST) && (r_row == 4'd15)));

  // Shadow frames. They hold a full frame steady so one scan never mixes two frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_red_shadow   <= '0;
      r_green_shadow <= '0;
    end else if (w_latch) begin
      r_red_shadow   <= red_array;
      r_green_shadow <= green_array;
    end
  end

  assign w_red_row   = r_red_shadow[r_row];
  assign w_green_row = r_green_shadow[r_row];
`else
  // Live mode: the columns follow the inputs directly, so a mid-frame change shows on the next drive cycle.
  assign w_red_row   = red_array[r_row];
  assign w_green_row = green_array[r_row];
`endif

  // Output decode. Only DRIVE lights the pins. row_idx tracks the row outside IDLE.
  always_comb begin
    row_out     = 16'h0000;
    red_col     = 16'h0000;
    green_col   = 16'h0000;
    row_idx     = 4'd0;
    frame_start = 1'b0;
    unique case (r_ps)
      S_BLANK: begin
        row_idx     = r_row;
        frame_start = (r_row == 4'd0) && (r_cnt == '0);
      end
      S_DRIVE: begin
        row_idx   = r_row;
        row_out   = 16'h0001 << r_row;
        red_col   = w_red_row;
        green_col = w_green_row;
      end
      default: begin
        row_idx = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Testbench for led_matrix_scan with ROW_HOLD=16 and BLANK_CYCLES=2.
// A time-based reference model predicts every output on every cycle: row = t/16, blank when t%16<2, and frames latched every 256 cycles.
// Directed steps cover reset, the basic scan, tearing or live mode, enable drop and mid-scan reset, followed by a randomized run.
module tb_led_matrix_scan;

  localparam int HOLD  = 16;
  localparam int BLANK = 2;
  localparam int FRAME = 16 * HOLD;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [15:0][15:0] red_array;
  logic [15:0][15:0] green_array;
  logic [15:0]       row_out;
  logic [15:0]       red_col;
  logic [15:0]       green_col;
  logic [3:0]        row_idx;
  logic              frame_start;

  led_matrix_scan #(.ROW_HOLD(HOLD), .BLANK_CYCLES(BLANK)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .red_array   (red_array),
    .green_array (green_array),
    .row_out     (row_out),
    .red_col     (red_col),
    .green_col   (green_col),
    .row_idx     (row_idx),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: whether a scan is active, the cycles since scan start, and the latched frames.
  bit                m_act = 1'b0;
  int                m_t   = 0;
  logic [15:0][15:0] m_red;
  logic [15:0][15:0] m_green;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // One clock: advance the model on the edge, then check every output at the falling edge.
  task automatic tick();
    logic [15:0] e_row, e_red, e_grn;
    logic [3:0]  e_idx;
    logic        e_fs;
    int          r;
    int          pos;
    @(posedge clk);
    if (reset || !enable) begin
      m_act = 1'b0;
      m_t   = 0;
    end else if (!m_act) begin
      m_act   = 1'b1;
      m_t     = 0;
      m_red   = red_array;
      m_green = green_array;
    end else begin
      m_t++;
      if (m_t % FRAME == 0) begin
        m_red   = red_array;
        m_green = green_array;
      end
    end
    @(negedge clk);
    e_row = 16'h0; e_red = 16'h0; e_grn = 16'h0; e_idx = 4'd0; e_fs = 1'b0;
    if (m_act) begin
      r     = (m_t / HOLD) % 16;
      pos   = m_t % HOLD;
      e_idx = 4'(r);
      e_fs  = (m_t % FRAME == 0);
      if (pos >= BLANK) begin
        e_row = 16'(32'd1 << r);
`ifdef LED_SCAN_DOUBLE_BUFFER_EN
        e_red = m_red[r];
        e_grn = m_green[r];
`else
        e_red = red_array[r];
        e_grn = green_array[r];
`endif
      end
    end
    chk("row_out", row_out, e_row);
    chk("red_col", red_col, e_red);
    chk("green_col", green_col, e_grn);
    chk("row_idx", {12'h0, row_idx}, {12'h0, e_idx});
    chk("frame_start", {15'h0, frame_start}, {15'h0, e_fs});
    chk("onehot", {15'h0, ($countones(row_out) <= 1)}, 16'h0001);
  endtask

  // Advance until the model reaches scan cycle `target`. The loop is bounded, and row_idx confirms the arrival.
  task automatic run_to(input int target);
    int guard = 0;
    while (!(m_act && m_t == target) && guard < 4 * FRAME) begin
      tick();
      guard++;
    end
    chk("run_to_row", {12'h0, row_idx}, 16'((target / HOLD) % 16));
  endtask

  initial begin
    int rr;
    reset       = 1'b1;
    enable      = 1'b0;
    red_array   = '0;
    green_array = '0;

    // Reset, then idle with enable low.
    repeat (3) tick();
    reset = 1'b0;
    repeat (50) tick();

    // Basic scan: a diagonal on red.
    for (int r = 0; r < 16; r++) red_array[r] = 16'(16'h0001 << r);
    enable = 1'b1;
    tick();
    chk("first_fs", {15'h0, frame_start}, 16'h0001);
    repeat (BLANK) tick();
    tick();
    chk("row0_drive", row_out, 16'h0001);
    chk("row0_red", red_col, 16'h0001);
    run_to(FRAME);
    chk("period_fs", {15'h0, frame_start}, 16'h0001);
    run_to(FRAME + 5 * HOLD + BLANK);
    chk("row5_drive", row_out, 16'h0020);
    chk("row5_red", red_col, 16'h0020);
    run_to(2 * FRAME - 1);
    chk("row15_idx", {12'h0, row_idx}, 16'd15);
    tick();
    chk("wrap_blank0", row_out, 16'h0000);
    chk("wrap_idx", {12'h0, row_idx}, 16'd0);
    tick();
    chk("wrap_blank1", red_col, 16'h0000);
    tick();
    chk("wrap_row0", row_out, 16'h0001);

    // Tearing / live mode: green row 8 changes while row 3 drives.
    enable = 1'b0;
    tick();
    for (int r = 0; r < 16; r++) green_array[r] = 16'($urandom);
    green_array[8] = 16'hFFFF;
    enable = 1'b1;
    tick();
    run_to(3 * HOLD + BLANK + 1);
    green_array[8] = 16'h0000;
    run_to(8 * HOLD + BLANK);
`ifdef LED_SCAN_DOUBLE_BUFFER_EN
    chk("tear_row8_same_frame", green_col, 16'hFFFF);
`else
    chk("live_row8_same_frame", green_col, 16'h0000);
`endif
    run_to(FRAME + 8 * HOLD + BLANK);
    chk("tear_row8_next_frame", green_col, 16'h0000);

    // A change on the latch edge itself must be captured.
    run_to(2 * FRAME - 1);
    red_array[0] = 16'hA5C3;
    run_to(2 * FRAME + BLANK);
    chk("latch_edge_capture", red_col, 16'hA5C3);

    // Enable drop during row 7 drive, then restart.
    run_to(2 * FRAME + 7 * HOLD + 5);
    enable = 1'b0;
    tick();
    chk("drop_row_out", row_out, 16'h0000);
    chk("drop_red", red_col, 16'h0000);
    enable = 1'b1;
    tick();
    chk("restart_fs", {15'h0, frame_start}, 16'h0001);
    chk("restart_idx", {12'h0, row_idx}, 16'd0);

    // Reset during row 10.
    run_to(10 * HOLD + 4);
    reset = 1'b1;
    tick();
    chk("rst_row_out", row_out, 16'h0000);
    chk("rst_fs", {15'h0, frame_start}, 16'h0000);
    reset = 1'b0;
    tick();
    chk("post_rst_fs", {15'h0, frame_start}, 16'h0001);

    // Randomized run: random enable drops, random row updates, and updates on the latch edge.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(63, 0) == 0) enable = ~enable;
      if ($urandom_range(7, 0) == 0 || (m_act && (m_t % FRAME == FRAME - 1))) begin
        rr = $urandom_range(15, 0);
        red_array[rr]   = 16'($urandom);
        rr = $urandom_range(15, 0);
        green_array[rr] = 16'($urandom);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
